// File: rtl/pmem_line_responder_pkg.sv
// Shared types, widths and the fill-pattern helper for the line responder.
package pmem_pkg;
  localparam int LINE_BITS   = 128;
  localparam int OFFSET_BITS = 4;
  localparam int ADDR_BITS   = 16;

  typedef logic [LINE_BITS-1:0] line_t;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} pmem_state_t;

  typedef enum logic {OP_READ, OP_WRITE} pmem_op_t;

  // Line returned for never-written lines: each 16-bit word holds its own byte address.
  function automatic line_t fill_pattern(input logic [ADDR_BITS-1:0] addr);
    line_t      line;
    logic [2:0] word_idx;
    line = '0;
    for (int w = 0; w < 8; w++) begin
      word_idx = 3'(w);
      line[16*w +: 16] = {addr[ADDR_BITS-1:OFFSET_BITS], word_idx, 1'b0};
    end
    return line;
  endfunction
endpackage

// File: rtl/pmem_line_responder_if.sv
// Cache line-side bus: the cache is the master, the responder is the slave.
interface pmem_line_responder_if;
  import pmem_pkg::*;

  logic                 pmem_read;
  logic                 pmem_write;
  logic [ADDR_BITS-1:0] pmem_address;
  line_t                pmem_wdata;
  logic                 pmem_resp;
  line_t                pmem_rdata;
  logic                 busy;

  modport master (
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_resp, pmem_rdata, busy
  );

  modport slave (
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_resp, pmem_rdata, busy
  );
endinterface

// File: rtl/pmem_line_responder_line_store.sv
// Line data array with per-line valid bits; synchronous write, combinational read.
module line_store
  import pmem_pkg::*;
#(
  parameter int DEPTH_LINES = 64,
  parameter int IDX_W       = $clog2(DEPTH_LINES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [IDX_W-1:0] widx,
  input  line_t            wdata,
  input  logic [IDX_W-1:0] ridx,
  output line_t            rdata,
  output logic             rvalid
);
  line_t                  mem [DEPTH_LINES];
  logic [DEPTH_LINES-1:0] valid;

  // Data array is never reset; the valid bits decide whether its contents matter.
  always_ff @(posedge clk) begin
    if (we) mem[widx] <= wdata;
  end

  // Valid bits clear on reset so every line reads as the fill pattern afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  valid <= '0;
    else if (we) valid[widx] <= 1'b1;
  end

  assign rdata  = mem[ridx];
  assign rvalid = valid[ridx];
endmodule

// File: rtl/pmem_line_responder.sv
// Fixed-latency memory responder for the cache's 128-bit line port.
module pmem_line_responder
  import pmem_pkg::*;
#(
  parameter int LATENCY     = 4,
  parameter int DEPTH_LINES = 64
) (
  input logic                  clk,
  input logic                  rst_n,
  pmem_line_responder_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH_LINES);
  localparam int CNT_W = $clog2(LATENCY + 1);

  pmem_state_t          state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  pmem_op_t             op_reg, op_next;
  logic [ADDR_BITS-1:0] addr_reg, addr_next;
  line_t                wdata_reg, wdata_next;
  logic                 resp_reg, busy_reg;
  line_t                rdata_reg;

  logic                 load_rdata;
  logic                 commit;
  line_t                store_rdata;
  logic                 store_rvalid;

  // Writes commit on the edge leaving RESP, so a reset during the request drops them.
  assign commit = (state_reg == RESP) && (op_reg == OP_WRITE);

  line_store #(
    .DEPTH_LINES (DEPTH_LINES),
    .IDX_W       (IDX_W)
  ) u_store (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (commit),
    .widx   (addr_reg[OFFSET_BITS +: IDX_W]),
    .wdata  (wdata_reg),
    .ridx   (addr_next[OFFSET_BITS +: IDX_W]),
    .rdata  (store_rdata),
    .rvalid (store_rvalid)
  );

  // Next-state logic; *_next carry the effective request so LATENCY=1 can skip BUSY.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    op_next    = op_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    case (state_reg)
      IDLE: begin
        if (bus.pmem_write || bus.pmem_read) begin
          op_next    = bus.pmem_write ? OP_WRITE : OP_READ;
          addr_next  = bus.pmem_address;
          if (bus.pmem_write) wdata_next = bus.pmem_wdata;
          cnt_next   = CNT_W'(LATENCY - 1);
          state_next = (LATENCY == 1) ? RESP : BUSY;
        end
      end
      BUSY: begin
        if (cnt_reg != '0) cnt_next = cnt_reg - CNT_W'(1);
        if (cnt_reg <= CNT_W'(1)) state_next = RESP;
      end
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign load_rdata = (state_next == RESP) && (state_reg != RESP) && (op_next == OP_READ);

  // FSM, latency counter and captured request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      op_reg    <= OP_READ;
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      op_reg    <= op_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
    end
  end

  // Registered outputs; read data is held until the next read response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      rdata_reg <= '0;
    end else begin
      resp_reg <= (state_next == RESP);
      busy_reg <= (state_next != IDLE);
      if (load_rdata) rdata_reg <= store_rvalid ? store_rdata : fill_pattern(addr_next);
    end
  end

  assign bus.pmem_resp  = resp_reg;
  assign bus.busy       = busy_reg;
  assign bus.pmem_rdata = rdata_reg;
endmodule
